// File: rtl/vga_pkg.sv
// vga_pkg: 640x480@60 raster constants, frame-buffer address width and pixel types
package vga_pkg;
  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_H_FP = 16;
  localparam int VGA_H_SYNC = 96;
  localparam int VGA_H_BP = 48;
  localparam int VGA_V_ACTIVE = 480;
  localparam int VGA_V_FP = 10;
  localparam int VGA_V_SYNC = 2;
  localparam int VGA_V_BP = 33;
  localparam int VGA_H_TOTAL = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;
  localparam int VGA_V_TOTAL = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;
  localparam int VGA_HS_START = VGA_H_ACTIVE + VGA_H_FP;
  localparam int VGA_HS_END = VGA_HS_START + VGA_H_SYNC - 1;
  localparam int VGA_VS_START = VGA_V_ACTIVE + VGA_V_FP;
  localparam int VGA_VS_END = VGA_VS_START + VGA_V_SYNC - 1;
  localparam int ADDR_W = 19;
  localparam int CNT_W = 10;
  typedef struct packed {
    logic [4:0] r;
    logic [5:0] g;
    logic [4:0] b;
  } rgb565_t;
  typedef struct packed {
    logic de;
    logic hs;
    logic vs;
    logic fs;
  } ctl_t;
endpackage

// File: rtl/vga_frame_reader_if.sv
// vga_frame_reader_if: frame-buffer read port, buffer handshake and VGA pins
interface vga_frame_reader_if;
  import vga_pkg::*;
  logic frame_done;
  logic rd_buf;
  logic [ADDR_W:0] r_addr;
  rgb565_t r_data;
  logic vga_hsync_n;
  logic vga_vsync_n;
  logic vga_de;
  logic [3:0] vga_r;
  logic [3:0] vga_g;
  logic [3:0] vga_b;
  logic frame_start;
  modport master (
    input frame_done, r_data,
    output rd_buf, r_addr, vga_hsync_n, vga_vsync_n, vga_de, vga_r, vga_g, vga_b, frame_start
  );
  modport slave (
    output frame_done, r_data,
    input rd_buf, r_addr, vga_hsync_n, vga_vsync_n, vga_de, vga_r, vga_g, vga_b, frame_start
  );
endinterface

// File: rtl/vga_timing.sv
// vga_timing: free-running h/v raster counters with active, sync and frame-wrap decode
module vga_timing
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = VGA_H_ACTIVE,
  parameter int H_FP = VGA_H_FP,
  parameter int H_SYNC = VGA_H_SYNC,
  parameter int H_BP = VGA_H_BP,
  parameter int V_ACTIVE = VGA_V_ACTIVE,
  parameter int V_FP = VGA_V_FP,
  parameter int V_SYNC = VGA_V_SYNC,
  parameter int V_BP = VGA_V_BP
) (
  input  logic clk,
  input  logic rst_n,
  output logic active,
  output logic hs,
  output logic vs,
  output logic first,
  output logic wrap
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HS_START = H_ACTIVE + H_FP;
  localparam int HS_END = HS_START + H_SYNC - 1;
  localparam int VS_START = V_ACTIVE + V_FP;
  localparam int VS_END = VS_START + V_SYNC - 1;
  logic [CNT_W-1:0] h_cnt;
  logic [CNT_W-1:0] v_cnt;
  logic h_end;
  logic v_end;
  assign h_end = h_cnt == CNT_W'(H_TOTAL - 1);
  assign v_end = v_cnt == CNT_W'(V_TOTAL - 1);
  assign wrap = h_end && v_end;
  assign first = (h_cnt == '0) && (v_cnt == '0);
  assign active = (h_cnt < CNT_W'(H_ACTIVE)) && (v_cnt < CNT_W'(V_ACTIVE));
  assign hs = (h_cnt >= CNT_W'(HS_START)) && (h_cnt <= CNT_W'(HS_END));
  assign vs = (v_cnt >= CNT_W'(VS_START)) && (v_cnt <= CNT_W'(VS_END));
  // h advances every pixel clock; v advances on each h wrap
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else begin
      h_cnt <= h_end ? '0 : h_cnt + 1'b1;
      v_cnt <= h_end ? (v_end ? '0 : v_cnt + 1'b1) : v_cnt;
    end
endmodule

// File: rtl/vga_frame_reader.sv
// vga_frame_reader: double-buffered frame-buffer scan-out onto a 2-stage VGA pipeline
module vga_frame_reader
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = VGA_H_ACTIVE,
  parameter int H_FP = VGA_H_FP,
  parameter int H_SYNC = VGA_H_SYNC,
  parameter int H_BP = VGA_H_BP,
  parameter int V_ACTIVE = VGA_V_ACTIVE,
  parameter int V_FP = VGA_V_FP,
  parameter int V_SYNC = VGA_V_SYNC,
  parameter int V_BP = VGA_V_BP
) (
  input  logic clk,
  input  logic rst_n,
  vga_frame_reader_if.master bus
);
  logic active;
  logic hs;
  logic vs;
  logic first;
  logic wrap;
  logic [ADDR_W-1:0] pix_addr;
  logic pending;
  logic rd_buf;
  ctl_t ctl_d;
  logic unused_lsbs;
  vga_timing #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
  ) u_timing (
    .clk(clk),
    .rst_n(rst_n),
    .active(active),
    .hs(hs),
    .vs(vs),
    .first(first),
    .wrap(wrap)
  );
  assign bus.rd_buf = rd_buf;
  assign bus.r_addr = {rd_buf, pix_addr};
  assign unused_lsbs = ^{bus.r_data.r[0], bus.r_data.g[1:0], bus.r_data.b[0]};
  // scan address walks active pixels; buffers swap only at the frame wrap so no frame mixes buffers
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      pix_addr <= '0;
      pending <= 1'b0;
      rd_buf <= 1'b0;
    end else begin
      pix_addr <= wrap ? '0 : active ? pix_addr + 1'b1 : pix_addr;
      rd_buf <= (wrap && (pending || bus.frame_done)) ? ~rd_buf : rd_buf;
      pending <= wrap ? 1'b0 : pending || bus.frame_done;
    end
  // stage 1: controls ride alongside the one-cycle RAM read
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) ctl_d <= '0;
    else ctl_d <= '{de: active, hs: hs, vs: vs, fs: first};
  // stage 2: registered pins, colour blanked outside active video
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      bus.vga_hsync_n <= 1'b1;
      bus.vga_vsync_n <= 1'b1;
      bus.vga_de <= 1'b0;
      bus.frame_start <= 1'b0;
      bus.vga_r <= '0;
      bus.vga_g <= '0;
      bus.vga_b <= '0;
    end else begin
      bus.vga_hsync_n <= ~ctl_d.hs;
      bus.vga_vsync_n <= ~ctl_d.vs;
      bus.vga_de <= ctl_d.de;
      bus.frame_start <= ctl_d.fs;
      bus.vga_r <= ctl_d.de ? bus.r_data.r[4:1] : '0;
      bus.vga_g <= ctl_d.de ? bus.r_data.g[5:2] : '0;
      bus.vga_b <= ctl_d.de ? bus.r_data.b[4:1] : '0;
    end
endmodule

// File: tb/tb_vga_frame_reader.sv
// tb_vga_frame_reader: full-size instance for pixel/line checks, reduced raster for frame/swap checks
module tb_vga_frame_reader;
  logic clk = 1'b0;
  logic rst_a = 1'b0;
  logic rst_b = 1'b0;
  logic b_second = 1'b0;
  int checks = 0;
  int failures = 0;
  int pos_a;
  int pos_b;
  logic [11:0] q_a[$];
  logic [11:0] q_b[$];
  int de_a = 0, falls_a = 0, last_fall_a = -1;
  logic prev_hs_a = 1'b1;
  int de_b = 0, vs_b = 0, fs_b = 0, hs_b = 0, last_fall_b = -1, addr_bad = 0, toggles = 0, off_wrap = 0;
  logic prev_hs_b = 1'b1;
  logic prev_buf = 1'b0;
  vga_frame_reader_if bus_a();
  vga_frame_reader_if bus_b();
  vga_frame_reader dut_a (.clk(clk), .rst_n(rst_a), .bus(bus_a));
  vga_frame_reader #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1)
  ) dut_b (.clk(clk), .rst_n(rst_b), .bus(bus_b));
  always #5 clk = ~clk;
  always @(posedge clk) bus_a.r_data <= bus_a.r_addr[15:0];
  always @(posedge clk) bus_b.r_data <= {bus_b.r_addr[19], bus_b.r_addr[14:0]};
  always @(posedge clk or negedge rst_a)
    if (!rst_a) pos_a <= 0;
    else pos_a <= pos_a + 1;
  always @(posedge clk or negedge rst_b)
    if (!rst_b) pos_b <= 0;
    else pos_b <= pos_b + 1;
  function automatic logic [11:0] exp_px(logic [15:0] d);
    return {d[15:12], d[10:7], d[4:1]};
  endfunction
  task automatic chk(string name, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask
  task automatic wait_a(int p);
    for (int i = 0; i < 5000 && pos_a != p; i++) begin
      @(negedge clk);
      #1;
    end
    chk("wait_a", pos_a, p);
  endtask
  task automatic wait_b(int p);
    for (int i = 0; i < 2000 && pos_b != p; i++) begin
      @(negedge clk);
      #1;
    end
    chk("wait_b", pos_b, p);
  endtask
  task automatic pulse_b(int p);
    wait_b(p);
    bus_b.frame_done = 1'b1;
    @(negedge clk);
    #1;
    bus_b.frame_done = 1'b0;
  endtask
  task automatic push_frame_b(logic k);
    for (int a = 0; a < 48; a++) q_b.push_back(exp_px({k, 15'(a)}));
  endtask
  // scoreboard and line/frame statistics for the full-size instance
  always @(negedge clk) begin
    if (rst_a) begin
      if (bus_a.vga_de && q_a.size() > 0) chk("pix_a", {bus_a.vga_r, bus_a.vga_g, bus_a.vga_b}, q_a.pop_front());
      if (pos_a >= 2 && pos_a < 2402) begin
        if (bus_a.vga_de) de_a++;
        if (prev_hs_a && !bus_a.vga_hsync_n) begin
          if (last_fall_a >= 0) chk("hs_gap_a", pos_a - last_fall_a, 800);
          last_fall_a = pos_a;
          falls_a++;
        end
      end
    end
    prev_hs_a = bus_a.vga_hsync_n;
  end
  // scoreboard, frame statistics and buffer-swap tracking for the reduced instance
  always @(negedge clk) begin
    if (rst_b) begin
      if (bus_b.vga_de && q_b.size() > 0) chk("pix_b", {bus_b.vga_r, bus_b.vga_g, bus_b.vga_b}, q_b.pop_front());
      if (!b_second && pos_b >= 2 && pos_b < 302) begin
        if (bus_b.vga_de) de_b++;
        if (!bus_b.vga_vsync_n) vs_b++;
        if (bus_b.frame_start) fs_b++;
        if (prev_hs_b && !bus_b.vga_hsync_n) begin
          if (last_fall_b >= 0) chk("hs_gap_b", pos_b - last_fall_b, 15);
          last_fall_b = pos_b;
          hs_b++;
        end
      end
      if (!b_second && pos_b >= 150 && pos_b < 300 && bus_b.r_addr[19] !== 1'b1) addr_bad++;
      if (bus_b.rd_buf !== prev_buf) begin
        toggles++;
        if (pos_b % 150 != 0) off_wrap++;
      end
    end
    prev_hs_b = bus_b.vga_hsync_n;
    prev_buf = bus_b.rd_buf;
  end
  initial begin
    bus_a.frame_done = 1'b0;
    bus_b.frame_done = 1'b0;
    for (int v = 0; v < 3; v++)
      for (int h = 0; h < 640; h++) q_a.push_back(exp_px(16'(v * 640 + h)));
    push_frame_b(1'b0);
    push_frame_b(1'b1);
    push_frame_b(1'b0);
    push_frame_b(1'b1);
    push_frame_b(1'b1);
    push_frame_b(1'b1);
    repeat (3) @(negedge clk);
    #1;
    chk("rst_a", {bus_a.vga_hsync_n, bus_a.vga_vsync_n, bus_a.vga_de, bus_a.vga_r, bus_a.vga_g, bus_a.vga_b, bus_a.frame_start, bus_a.rd_buf, bus_a.r_addr}, {2'b11, 35'd0});
    chk("rst_b", {bus_b.vga_hsync_n, bus_b.vga_vsync_n, bus_b.vga_de, bus_b.vga_r, bus_b.vga_g, bus_b.vga_b, bus_b.frame_start, bus_b.rd_buf, bus_b.r_addr}, {2'b11, 35'd0});
    @(negedge clk);
    rst_a = 1'b1;
    rst_b = 1'b1;
    fork
      begin
        wait_a(1);
        chk("fs_early", bus_a.frame_start, 0);
        wait_a(2);
        chk("fs_first", {bus_a.frame_start, bus_a.vga_de, bus_a.vga_hsync_n, bus_a.vga_vsync_n}, 4'b1111);
        wait_a(1607);
        chk("pix_1285", {bus_a.vga_de, bus_a.vga_r, bus_a.vga_g, bus_a.vga_b}, {1'b1, 12'h0A2});
        wait_a(2402);
        chk("hs_falls_a", falls_a, 3);
        chk("de_lines_a", de_a, 1920);
        chk("sb_a_drain", q_a.size(), 0);
      end
      begin
        #1;
        chk("addr0_b", bus_b.r_addr, 0);
        pulse_b(20);
        chk("pend_set", dut_b.pending, 1);
        wait_b(149);
        chk("buf_hold", bus_b.rd_buf, 0);
        wait_b(150);
        chk("swap1", {bus_b.rd_buf, dut_b.pending}, 2'b10);
        pulse_b(160);
        pulse_b(200);
        wait_b(299);
        chk("buf_f1", bus_b.rd_buf, 1);
        wait_b(300);
        chk("swap2", {bus_b.rd_buf, dut_b.pending}, 2'b00);
        wait_b(302);
        chk("de_frames", de_b, 96);
        chk("vs_low", vs_b, 60);
        chk("lines", hs_b, 20);
        chk("fs_count", fs_b, 2);
        chk("addr19_f1", addr_bad, 0);
        chk("toggles_f2", toggles, 2);
        pulse_b(449);
        chk("swap_wrap", {bus_b.rd_buf, dut_b.pending}, 2'b10);
        chk("toggles_f3", toggles, 3);
        wait_b(900);
        chk("hold_3f", toggles, 3);
        chk("buf_3f", bus_b.rd_buf, 1);
        pulse_b(905);
        wait_b(965);
        chk("pend_pre_rst", dut_b.pending, 1);
        #2;
        rst_b = 1'b0;
        #1;
        chk("rst_async", {bus_b.vga_hsync_n, bus_b.vga_vsync_n, bus_b.vga_de, bus_b.vga_r, bus_b.vga_g, bus_b.vga_b, bus_b.frame_start, bus_b.rd_buf, bus_b.r_addr}, {2'b11, 35'd0});
        chk("rst_pend", dut_b.pending, 0);
        b_second = 1'b1;
        push_frame_b(1'b0);
        push_frame_b(1'b0);
        repeat (3) @(negedge clk);
        rst_b = 1'b1;
        #1;
        chk("addr0_post", {bus_b.rd_buf, bus_b.r_addr}, 0);
        wait_b(2);
        chk("fs_post", {bus_b.frame_start, bus_b.vga_de, bus_b.vga_r, bus_b.vga_g, bus_b.vga_b}, {2'b11, 12'h000});
        wait_b(151);
        chk("no_swap_post", bus_b.rd_buf, 0);
        chk("off_wrap", off_wrap, 0);
        wait_b(302);
        chk("sb_b_drain", q_b.size(), 0);
      end
    join
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/vga_frame_reader.md
VGA_FRAME_READER -- requirements
Module: vga_frame_reader

Interface
REQ-001 Parameters: H_ACTIVE 640, H_FP 16, H_SYNC 96, H_BP 48, V_ACTIVE 480, V_FP 10, V_SYNC 2, V_BP 33 (pixel geometry and porches; totals are 800 x 525).
REQ-002 clk  in  1  pixel clock, 25 MHz; all logic is clocked on the rising edge.
REQ-003 rst_n  in  1  asynchronous, active-low reset.
REQ-004 frame_done  in  1  one-cycle pulse from the capture side: a full frame has been written to buffer ~rd_buf.
REQ-005 rd_buf  out  1  index of the buffer currently being displayed; the capture side writes buffer ~rd_buf.
REQ-006 r_addr  out  20  frame-buffer read address {rd_buf, pix_addr[18:0]}.
REQ-007 r_data  in  16  RGB565 read data, valid exactly 1 cycle after r_addr.
REQ-008 vga_hsync_n, vga_vsync_n  out  1 each  active-low syncs.
REQ-009 vga_de  out  1  active-video qualifier.
REQ-010 vga_r, vga_g, vga_b  out  4 each  colour outputs.
REQ-011 frame_start  out  1  one-cycle pulse aligned with the output of pixel (0,0).

Function
REQ-012 Counter stage: h_cnt 0..799, v_cnt 0..524; h_cnt increments every cycle and wraps 799->0; v_cnt increments on the h wrap and wraps 524->0.
REQ-013 active = (h_cnt < 640) && (v_cnt < 480); hs = (656 <= h_cnt <= 751); vs = (490 <= v_cnt <= 491).
REQ-014 pix_addr equals v_cnt*640 + h_cnt while active, generated incrementally (no multiplier), increments after each active cycle, resets to 0 when the counters transition to (0,0), and holds its value outside active.
REQ-015 r_addr is driven from registered state in the same cycle as the counter position it addresses.
REQ-016 Output latency is 2 cycles from counter stage to vga_* pins, and hsync, vsync, de and frame_start are delayed by 2 cycles to stay aligned with colour.
REQ-017 Colour outputs: vga_r = r_data[15:12], vga_g = r_data[10:7], vga_b = r_data[4:1], registered; all three are forced to 0 when the delayed de is 0.
REQ-018 The module holds a pending flag: frame_done sets pending, and a frame_done arriving while pending is already 1 is absorbed with no error.
REQ-019 Swap: on the cycle the counters go (799,524)->(0,0), if pending || frame_done, then rd_buf toggles and pending clears; otherwise rd_buf holds.
REQ-020 A frame_done arriving on the swap cycle is consumed by that swap, and pending is 0 afterwards.
REQ-021 rd_buf never changes at any point other than the frame wrap, so no frame is displayed from mixed buffers.

Reset
REQ-022 While rst_n is 0, the following are held: h_cnt=0, v_cnt=0, pix_addr=0, pending=0, rd_buf=0, r_addr=0, vga_hsync_n=1, vga_vsync_n=1, vga_de=0, rgb=0, frame_start=0, and the delay pipeline is cleared.
REQ-023 After release, the first counter cycle is (0,0), and frame_start is asserted 2 cycles after release.
REQ-024 Assertion of reset mid-frame takes effect immediately (asynchronously), and any pending swap is discarded.

Structure
REQ-025 Package vga_pkg holds the timing constants, the derived totals (800, 525), the sync-window bounds, the address width (19) and a typedef for the RGB565 pixel.
REQ-026 Sub-module vga_timing contains the h/v counters plus active/hs/vs/frame-wrap generation; vga_frame_reader adds addressing, buffer swap and the output pipeline.

Verification
REQ-027 Free run after reset, 2 frames: exactly 800 clk between hsync falling edges; vsync low for 1600 clk; 525 lines per frame; 307200 de-high cycles per frame.
REQ-028 RAM model returns r_data = r_addr[15:0], 1-cycle latency: pixel (h=5,v=2) appears with addr 1285, and vga_r/g/b equals the fields of 1285 exactly 2 cycles after the counter reaches (5,2).
REQ-029 frame_done pulsed at line 100 of frame 0: rd_buf becomes 1 at the start of frame 1, r_addr[19]=1 throughout frame 1, and pending=0.
REQ-030 Two frame_done pulses within frame 0: exactly one toggle at the wrap; frame_done on the exact wrap cycle: immediate toggle, pending=0.
REQ-031 No frame_done for 3 frames: rd_buf is constant.
REQ-032 rst_n asserted at (300,200) with pending=1: outputs are at reset values immediately; after release rd_buf=0, pending=0, and the first pixel output reads address 0.
